vga_rect_fill: RTL and testbench
================================

Name: vga_rect_fill

Overview:
- IOBUS write initiator for the 80x60 VGA framebuffer.
- Fills a rectangle with a single 8-bit colour by issuing alternating address and colour writes to the framebuffer MMIO ports (VGA_ADDR_AD, then VGA_COLOR_AD).
- Sits beside the MCU on the IOBUS behind an arbiter. Frees the CPU from per-pixel stores when drawing paddles, ball and background.

Parameters:
- SCR_W, 80, screen width in pixels.
- SCR_H, 60, screen height in pixels.
- VGA_ADDR_AD, 32'h11100000, framebuffer address-register MMIO address.
- VGA_COLOR_AD, 32'h11140000, framebuffer colour/write-strobe MMIO address.

Ports:
- CLK  in  1  system clock (50 MHz MCU clock).
- RESET  in  1  synchronous, active-high reset.
- START  in  1  request pulse; sampled only in IDLE.
- X  in  7  left column, 0..79.
- Y  in  6  top row, 0..59.
- W  in  7  width in pixels.
- H  in  6  height in pixels.
- COLOR  in  8  RRRGGGBB fill colour.
- BUS_GNT  in  1  arbiter grant; a write completes only in a cycle with IOBUS_WR=1 and BUS_GNT=1.
- IOBUS_ADDR  out  32  write address.
- IOBUS_OUT  out  32  write data.
- IOBUS_WR  out  1  write request.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset values (clock and reset as stated: CLK, synchronous active-high RESET): IOBUS_WR=0, IOBUS_ADDR=0, IOBUS_OUT=0, BUSY=0, DONE=0, state IDLE.
- RESET asserted mid-fill: next edge returns to IDLE with IOBUS_WR=0. No further writes occur and DONE is not pulsed.
- FSM states: IDLE, WR_ADDR, WR_COLOR, LAST.
  - IDLE: when START=1, latch X, Y, W, H, COLOR.
    - If W=0 or H=0, go to LAST (no writes).
    - Otherwise go to WR_ADDR.
    - START is ignored in every state other than IDLE.
  - WR_ADDR: IOBUS_WR=1, IOBUS_ADDR=VGA_ADDR_AD, IOBUS_OUT={19'b0, pix_addr[12:0]}. On grant, go to WR_COLOR.
  - WR_COLOR: IOBUS_WR=1, IOBUS_ADDR=VGA_COLOR_AD, IOBUS_OUT={24'b0, colour}. On grant, advance the pixel.
    - Go to LAST if this was the final pixel, else go to WR_ADDR.
  - LAST: IOBUS_WR=0, DONE=1 for exactly one cycle, then IDLE.
- While BUS_GNT=0, the state and all IOBUS outputs hold stable. IOBUS_WR is never dropped once raised until granted.
- Address generation: no multiplier.
  - Start address is (Y<<6)+(Y<<4)+X, 13-bit.
  - Column walk: pix_addr+1.
  - End of row: row_base+SCR_W, then pix_addr=new row_base.
  - Raster order: left to right, then top to bottom.
- Counters: col_cnt 7-bit and row_cnt 6-bit, counting latched width/height down to 1.
- Latency with BUS_GNT held at 1:
  - START at cycle 0, first address write at cycle 1.
  - Each pixel takes 2 cycles.
  - DONE at cycle 1+2*W*H.
  - Zero-size rectangle: DONE at cycle 1.
- BUSY=1 in WR_ADDR and WR_COLOR; BUSY=0 in IDLE and LAST.
- Maximum rectangle of 4800 pixels: every generated address is at most 4799 and fits 13 bits.

Optional Feature:
- Macro: VGA_RECT_FILL_CLIP_EN.
- Defined: at START, the effective width is min(W, SCR_W-X) and the effective height is min(H, SCR_H-Y).
  - If X>=SCR_W or Y>=SCR_H, the rectangle is zero-size.
  - No write ever targets an off-screen pixel.
- Undefined: W and H are used verbatim; in-range inputs are the caller's responsibility.
  - An overhanging row continues linearly into the next row's addresses.
  - Addresses wrap modulo 8192 (13 bits).
  - This saves the comparators.

Decomposition:
- Shared package vga_pkg:
  - SCR_W and SCR_H.
  - The MMIO address constants VGA_ADDR_AD and VGA_COLOR_AD.
  - typedef vga_color_t (logic [7:0]).
  - typedef vga_addr_t (logic [12:0]).
  - FSM enum rect_state_t.
- One natural sub-module, vga_rect_addr_gen: holds row_base, pix_addr and the col/row counters. Inputs are load/step; outputs are pix_addr and last_pixel.
- The top-level FSM and the IOBUS driver live in vga_rect_fill.

Test Plan:
- X=10, Y=5, W=3, H=2, COLOR=8'hE0, BUS_GNT=1 -> address writes 410, 411, 412, 490, 491, 492, each followed by a COLOR write of 8'hE0; DONE at cycle 13.
- W=0, H=4, START -> no IOBUS_WR; DONE pulses at cycle 1; BUSY stays 0.
- X=0, Y=0, W=2, H=1, BUS_GNT low for cycles 1-4 -> IOBUS_WR=1 with ADDR=VGA_ADDR_AD and data 0 held unchanged; completion is delayed by 4 cycles; exactly 4 writes are granted.
- START pulsed again while BUSY on a 4x4 fill -> second request ignored; exactly 32 granted writes; a single DONE.
- RESET during the WR_COLOR of pixel 3 -> next cycle IOBUS_WR=0 and BUSY=0; no DONE; a new START then fills correctly from its own origin.
- Clip enabled: X=78, Y=58, W=5, H=5 -> only addresses 4718, 4719, 4798, 4799 written; DONE at cycle 9. Clip disabled: the same inputs produce 25 pixel writes starting at 4718.

Source files
------------

// File: rtl/vga_rect_fill_pkg.sv
// Shared definitions for the VGA rectangle-fill IOBUS initiator:
// screen geometry, MMIO addresses, pixel types and FSM states.
package vga_pkg;

  localparam int unsigned SCR_W = 80;
  localparam int unsigned SCR_H = 60;

  localparam logic [31:0] VGA_ADDR_AD  = 32'h1110_0000;
  localparam logic [31:0] VGA_COLOR_AD = 32'h1114_0000;

  typedef logic [7:0]  vga_color_t;
  typedef logic [12:0] vga_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    WR_ADDR,
    WR_COLOR,
    LAST
  } rect_state_t;

  localparam vga_addr_t ROW_STEP = 13'(SCR_W);

  // y*80 + x built from shifts: y*64 + y*16 + x.
  function automatic vga_addr_t start_addr(input logic [6:0] x, input logic [5:0] y);
    vga_addr_t yw;
    yw = {7'b0, y};
    return (yw << 6) + (yw << 4) + {6'b0, x};
  endfunction

endpackage

// File: rtl/vga_rect_fill_if.sv
// IOBUS write port between the rectangle filler (master) and the arbiter (slave).
interface vga_rect_fill_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic        BUS_GNT;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  BUS_GNT
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output BUS_GNT
  );
endinterface

// File: rtl/vga_rect_addr_gen.sv
// Raster address walker for the rectangle filler: row base, pixel address
// and column/row down-counters; no multiplier.
module vga_rect_addr_gen
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [6:0] x,
  input  logic [5:0] y,
  input  logic [6:0] w,
  input  logic [5:0] h,
  output vga_addr_t  pix_addr,
  output logic       last_pixel
);

  vga_addr_t  row_base;
  logic [6:0] col_cnt;
  logic [5:0] row_cnt;
  logic [6:0] width;
  vga_addr_t  next_row;

  always_comb begin
    last_pixel = (col_cnt == 7'd1) && (row_cnt == 6'd1);
    next_row   = row_base + ROW_STEP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_base <= '0;
      pix_addr <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      width    <= '0;
    end else if (load) begin
      row_base <= start_addr(x, y);
      pix_addr <= start_addr(x, y);
      col_cnt  <= w;
      row_cnt  <= h;
      width    <= w;
    end else if (step) begin
      if (col_cnt == 7'd1) begin
        row_base <= next_row;
        pix_addr <= next_row;
        col_cnt  <= width;
        row_cnt  <= row_cnt - 6'd1;
      end else begin
        pix_addr <= pix_addr + 13'd1;
        col_cnt  <= col_cnt - 7'd1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: alternating VGA_ADDR_AD / VGA_COLOR_AD writes on IOBUS.
// Optional macro VGA_RECT_FILL_CLIP_EN clips the rectangle to the screen at START.
module vga_rect_fill
  import vga_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [6:0]             X,
  input  logic [5:0]             Y,
  input  logic [6:0]             W,
  input  logic [5:0]             H,
  input  logic [7:0]             COLOR,
  vga_rect_fill_if.master        bus,
  output logic                   BUSY,
  output logic                   DONE
);

  rect_state_t state;
  vga_color_t  color_q;
  vga_addr_t   pix_addr;
  logic        last_pixel;
  logic [6:0]  eff_w;
  logic [5:0]  eff_h;
  logic        load;
  logic        step;

`ifdef VGA_RECT_FILL_CLIP_EN
  logic [7:0] room_x;
  logic [6:0] room_y;

  always_comb begin
    room_x = 8'(SCR_W) - {1'b0, X};
    room_y = 7'(SCR_H) - {1'b0, Y};
    eff_w  = W;
    eff_h  = H;
    if ({1'b0, X} >= 8'(SCR_W)) eff_w = '0;
    else if ({1'b0, W} > room_x) eff_w = room_x[6:0];
    if ({1'b0, Y} >= 7'(SCR_H)) eff_h = '0;
    else if ({1'b0, H} > room_y) eff_h = room_y[5:0];
  end
`else
  always_comb begin
    eff_w = W;
    eff_h = H;
  end
`endif

  always_comb begin
    load = (state == IDLE) && START;
    step = (state == WR_COLOR) && bus.BUS_GNT;
  end

  vga_rect_addr_gen u_addr_gen (
    .clk       (CLK),
    .rst       (RESET),
    .load      (load),
    .step      (step),
    .x         (X),
    .y         (Y),
    .w         (eff_w),
    .h         (eff_h),
    .pix_addr  (pix_addr),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      color_q      <= '0;
      bus.IOBUS_WR <= 1'b0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            color_q <= COLOR;
            if (eff_w == '0 || eff_h == '0) begin
              state <= LAST;
              DONE  <= 1'b1;
            end else begin
              state        <= WR_ADDR;
              bus.IOBUS_WR <= 1'b1;
              BUSY         <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (bus.BUS_GNT) state <= WR_COLOR;
        end
        WR_COLOR: begin
          if (bus.BUS_GNT) begin
            if (last_pixel) begin
              state        <= LAST;
              bus.IOBUS_WR <= 1'b0;
              BUSY         <= 1'b0;
              DONE         <= 1'b1;
            end else begin
              state <= WR_ADDR;
            end
          end
        end
        LAST: begin
          DONE  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address/data are a pure decode of registered state, pix_addr and colour,
  // so they stay stable while the grant is withheld.
  always_comb begin
    bus.IOBUS_ADDR = '0;
    bus.IOBUS_OUT  = '0;
    case (state)
      WR_ADDR: begin
        bus.IOBUS_ADDR = VGA_ADDR_AD;
        bus.IOBUS_OUT  = {19'b0, pix_addr};
      end
      WR_COLOR: begin
        bus.IOBUS_ADDR = VGA_COLOR_AD;
        bus.IOBUS_OUT  = {24'b0, color_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill with a write scoreboard; honours VGA_RECT_FILL_CLIP_EN.
module tb_vga_rect_fill;
  import vga_pkg::*;

  logic       clk;
  logic       RESET;
  logic       START;
  logic [6:0] X;
  logic [5:0] Y;
  logic [6:0] W;
  logic [5:0] H;
  logic [7:0] COLOR;
  logic       BUSY;
  logic       DONE;

  vga_rect_fill_if bus ();

  vga_rect_fill dut (
    .CLK  (clk),
    .RESET(RESET),
    .START(START),
    .X    (X),
    .Y    (Y),
    .W    (W),
    .H    (H),
    .COLOR(COLOR),
    .bus  (bus.master),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int gcount = 0;
  int done_cnt = 0;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference raster: pixel (r,c) lives at (Y+r)*80 + X + c, modulo 8192.
  task automatic push_fill(input int x, input int y, input int w, input int h, input int c);
    int ew, eh;
    logic [12:0] a;
    ew = w;
    eh = h;
`ifdef VGA_RECT_FILL_CLIP_EN
    if (x >= 80) ew = 0; else if (w > 80 - x) ew = 80 - x;
    if (y >= 60) eh = 0; else if (h > 60 - y) eh = 60 - y;
`endif
    for (int r = 0; r < eh; r++)
      for (int col = 0; col < ew; col++) begin
        a = 13'((y + r) * 80 + x + col);
        sb.push_back({VGA_ADDR_AD, 19'b0, a});
        sb.push_back({VGA_COLOR_AD, 24'b0, 8'(c)});
      end
  endtask

  always @(negedge clk) begin
    if (DONE) done_cnt++;
    if (bus.IOBUS_WR && bus.BUS_GNT) begin
      gcount++;
      if (sb.size() == 0) chk("unexpected_wr", 64'(sb.size()), 64'd1);
      else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("wr_addr", bus.IOBUS_ADDR, e[63:32]);
        chk("wr_data", bus.IOBUS_OUT, e[31:0]);
      end
    end
  end

  task automatic start_fill(input int x, input int y, input int w, input int h,
                            input int c, input bit model);
    X = 7'(x); Y = 6'(y); W = 7'(w); H = 6'(h); COLOR = 8'(c);
    START = 1'b1;
    if (model) push_fill(x, y, w, h, c);
    @(posedge clk);
    #1 START = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, output int lat,
                           output bit busy_seen, output bit wr_seen);
    lat = start_cnt;
    busy_seen = 0;
    wr_seen = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      lat++;
      if (BUSY) busy_seen = 1;
      if (bus.IOBUS_WR) wr_seen = 1;
      if (DONE) break;
    end
    chk("done_seen", 64'(DONE), 64'd1);
    chk("busy_in_last", 64'(BUSY), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(DONE), 64'd0);
  endtask

  int  lat, g0, d0;
  bit  bs, ws;

  initial begin
    RESET = 1'b1; START = 1'b0; bus.BUS_GNT = 1'b1;
    X = '0; Y = '0; W = '0; H = '0; COLOR = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr", 64'(bus.IOBUS_WR), 64'd0);
    chk("rst_addr", bus.IOBUS_ADDR, 64'd0);
    chk("rst_out", bus.IOBUS_OUT, 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    @(posedge clk);
    #1 RESET = 1'b0;

    // 3x2 fill at (10,5): 410..412, 490..492
    @(negedge clk);
    start_fill(10, 5, 3, 2, 'hE0, 1);
    wait_done(0, lat, bs, ws);
    chk("lat_3x2", 64'(lat), 64'd13);
    chk("sb_3x2", 64'(sb.size()), 64'd0);

    // zero width
    @(negedge clk);
    g0 = gcount;
    start_fill(0, 0, 0, 4, 'h1F, 1);
    wait_done(0, lat, bs, ws);
    chk("lat_zero", 64'(lat), 64'd1);
    chk("busy_zero", 64'(bs), 64'd0);
    chk("wr_zero", 64'(ws), 64'd0);
    chk("gnt_zero", 64'(gcount - g0), 64'd0);

    // grant withheld cycles 1-4
    @(negedge clk);
    g0 = gcount;
    bus.BUS_GNT = 1'b0;
    start_fill(0, 0, 2, 1, 'h55, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_wr", 64'(bus.IOBUS_WR), 64'd1);
      chk("stall_addr", bus.IOBUS_ADDR, 64'(VGA_ADDR_AD));
      chk("stall_out", bus.IOBUS_OUT, 64'd0);
    end
    @(posedge clk);
    #1 bus.BUS_GNT = 1'b1;
    wait_done(4, lat, bs, ws);
    chk("lat_stall", 64'(lat), 64'd9);
    chk("gnt_stall", 64'(gcount - g0), 64'd4);

    // second START while busy is ignored
    @(negedge clk);
    g0 = gcount;
    d0 = done_cnt;
    start_fill(3, 20, 4, 4, 'h0C, 1);
    repeat (3) @(posedge clk);
    #1;
    X = 7'd40; Y = 6'd40; W = 7'd2; H = 6'd2; COLOR = 8'hFF; START = 1'b1;
    @(posedge clk);
    #1 START = 1'b0;
    wait_done(4, lat, bs, ws);
    chk("lat_4x4", 64'(lat), 64'd33);
    repeat (3) @(negedge clk);
    chk("gnt_4x4", 64'(gcount - g0), 64'd32);
    chk("done_4x4", 64'(done_cnt - d0), 64'd1);
    chk("sb_4x4", 64'(sb.size()), 64'd0);

    // reset during WR_COLOR of pixel 3 (cycle 6)
    @(negedge clk);
    d0 = done_cnt;
    start_fill(5, 2, 4, 1, 'h3A, 0);
    push_fill(5, 2, 3, 1, 'h3A);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_rst_addr", bus.IOBUS_ADDR, 64'(VGA_COLOR_AD));
    RESET = 1'b1;
    @(posedge clk);
    #1 RESET = 1'b0;
    @(negedge clk);
    chk("post_rst_wr", 64'(bus.IOBUS_WR), 64'd0);
    chk("post_rst_busy", 64'(BUSY), 64'd0);
    repeat (4) @(negedge clk);
    chk("post_rst_done", 64'(done_cnt - d0), 64'd0);
    chk("post_rst_sb", 64'(sb.size()), 64'd0);
    start_fill(20, 7, 2, 2, 'h81, 1);
    wait_done(0, lat, bs, ws);
    chk("lat_after_rst", 64'(lat), 64'd9);

    // corner overhang (78,58) 5x5
    @(negedge clk);
    g0 = gcount;
    start_fill(78, 58, 5, 5, 'h92, 1);
    wait_done(0, lat, bs, ws);
`ifdef VGA_RECT_FILL_CLIP_EN
    chk("lat_corner", 64'(lat), 64'd9);
    chk("gnt_corner", 64'(gcount - g0), 64'd8);
`else
    chk("lat_corner", 64'(lat), 64'd51);
    chk("gnt_corner", 64'(gcount - g0), 64'd50);
`endif
    chk("sb_final", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
